// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding and default sizing.
package intr_pkg;

    localparam int NSRC_DEF    = 4;
    localparam int CAUSE_W_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } intr_state_e;

endpackage

// File: rtl/intr_ctrl_if.sv
// Intr/Inta handshake bundle between the interrupt controller (slave) and the CPU side (master).
interface intr_ctrl_if #(
    parameter int NSRC    = 4,
    parameter int CAUSE_W = 2
);
    logic [NSRC-1:0]    Irq;
    logic               Ie;
    logic               Mask_we;
    logic [NSRC-1:0]    Mask_d;
    logic               Inta;
    logic               Eret;
    logic               Intr;
    logic [CAUSE_W-1:0] Cause;
    logic [NSRC-1:0]    Pending;
    logic [NSRC-1:0]    Mask_q;
    logic               Busy;

    modport master (
        output Irq, Ie, Mask_we, Mask_d, Inta, Eret,
        input  Intr, Cause, Pending, Mask_q, Busy
    );

    modport slave (
        input  Irq, Ie, Mask_we, Mask_d, Inta, Eret,
        output Intr, Cause, Pending, Mask_q, Busy
    );
endinterface

// File: rtl/intr_prio_enc.sv
// Combinational priority encoder: reports the lowest set index of act (index 0 wins).
module intr_prio_enc #(
    parameter int NSRC    = 4,
    parameter int CAUSE_W = 2
) (
    input  logic [NSRC-1:0]    act,
    output logic [CAUSE_W-1:0] idx,
    output logic               any
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            idx = act[i] ? CAUSE_W'(i) : idx;
            any = any | act[i];
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller top: edge-latched pending bits, mask, request/ack/return FSM.
// Defining INTR_SYNC_EN inserts a 2-flop synchronizer on every Irq bit.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int              NSRC     = NSRC_DEF,
    parameter int              CAUSE_W  = CAUSE_W_DEF,
    parameter logic [NSRC-1:0] MASK_RST = {NSRC{1'b1}}
) (
    input logic        Clk,
    input logic        Clrn,
    intr_ctrl_if.slave bus
);

    logic [NSRC-1:0]    irq_s;
    logic [NSRC-1:0]    rise_s;
    logic [NSRC-1:0]    act_s;
    logic [NSRC-1:0]    clr_s;
    logic [CAUSE_W-1:0] idx_s;
    logic               any_s;

    logic [NSRC-1:0]    irq_dly_q, irq_dly_d;
    logic [NSRC-1:0]    pending_q, pending_d;
    logic [NSRC-1:0]    mask_q,    mask_d;
    logic [CAUSE_W-1:0] cause_q,   cause_d;
    intr_state_e        state_q,   state_d;
    logic               intr_q,    intr_d;
    logic               busy_q,    busy_d;

`ifdef INTR_SYNC_EN
    logic [NSRC-1:0] sync1_q;
    logic [NSRC-1:0] sync2_q;

    // Two-stage synchronizer for asynchronous interrupt sources.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.Irq;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = bus.Irq;
`endif

    intr_prio_enc #(
        .NSRC    (NSRC),
        .CAUSE_W (CAUSE_W)
    ) u_prio (
        .act (act_s),
        .idx (idx_s),
        .any (any_s)
    );

    // Next-state logic for edge detector, pending/mask registers and the handshake FSM.
    always_comb begin
        irq_dly_d = irq_s;
        rise_s    = irq_s & ~irq_dly_q;
        act_s     = pending_q & mask_q;
        state_d   = state_q;
        cause_d   = cause_q;
        clr_s     = '0;

        case (state_q)
            ST_IDLE: begin
                if (any_s && bus.Ie) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.Inta) begin
                    if (any_s) begin
                        state_d = ST_SERVICE;
                        cause_d = idx_s;
                        clr_s   = {{(NSRC-1){1'b0}}, 1'b1} << idx_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!any_s || !bus.Ie) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (bus.Eret) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A fresh rise beats the acknowledge clear on the same bit.
        pending_d = (pending_q & ~clr_s) | rise_s;

        if (bus.Mask_we) begin
            mask_d = bus.Mask_d;
        end else begin
            mask_d = mask_q;
        end

        intr_d = (state_d == ST_REQ);
        busy_d = (state_d == ST_SERVICE);
    end

    // State registers; outputs are flopped copies of the next-state decode.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            irq_dly_q <= '0;
            pending_q <= '0;
            mask_q    <= MASK_RST;
            cause_q   <= '0;
            state_q   <= ST_IDLE;
            intr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            irq_dly_q <= irq_dly_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            cause_q   <= cause_d;
            state_q   <= state_d;
            intr_q    <= intr_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.Intr    = intr_q;
    assign bus.Busy    = busy_q;
    assign bus.Cause   = cause_q;
    assign bus.Pending = pending_q;
    assign bus.Mask_q  = mask_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl (works with or without INTR_SYNC_EN).
module tb_intr_ctrl;

    logic clk;
    logic clrn;
    int   checks;
    int   errors;

    intr_ctrl_if #(.NSRC(4), .CAUSE_W(2)) bus ();

    intr_ctrl #(
        .NSRC     (4),
        .CAUSE_W  (2),
        .MASK_RST (4'b1111)
    ) dut (
        .Clk  (clk),
        .Clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_intr(output int n);
        n = 0;
        while (bus.Intr !== 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
    endtask

    task automatic pulse_inta();
        bus.Inta = 1'b1;
        tick(1);
        bus.Inta = 1'b0;
    endtask

    task automatic pulse_eret();
        bus.Eret = 1'b1;
        tick(1);
        bus.Eret = 1'b0;
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        bus.Irq = 4'b0000; bus.Ie = 1'b1; bus.Mask_we = 1'b0; bus.Mask_d = 4'b0000;
        bus.Inta = 1'b0; bus.Eret = 1'b0;
        tick(2);
        checks++; if (bus.Intr !== 1'b0) begin errors++; $display("FAIL reset_intr got %b exp 0", bus.Intr); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.Busy); end
        checks++; if (bus.Pending !== 4'b0000) begin errors++; $display("FAIL reset_pending got %b exp 0000", bus.Pending); end
        checks++; if (bus.Mask_q !== 4'b1111) begin errors++; $display("FAIL reset_mask got %b exp 1111", bus.Mask_q); end
        checks++; if (bus.Cause !== 2'd0) begin errors++; $display("FAIL reset_cause got %0d exp 0", bus.Cause); end
        clrn = 1'b1;
        tick(1);
    endtask

    task automatic test_basic();
        int n;
        int exp_lat;
`ifdef INTR_SYNC_EN
        exp_lat = 4;
`else
        exp_lat = 2;
`endif
        bus.Irq = 4'b0100;
        wait_intr(n);
        checks++; if (n !== exp_lat) begin errors++; $display("FAIL basic_latency got %0d exp %0d", n, exp_lat); end
        checks++; if (bus.Pending !== 4'b0100) begin errors++; $display("FAIL basic_pending got %b exp 0100", bus.Pending); end
        pulse_inta();
        checks++; if (bus.Cause !== 2'd2) begin errors++; $display("FAIL basic_cause got %0d exp 2", bus.Cause); end
        checks++; if (bus.Pending !== 4'b0000) begin errors++; $display("FAIL basic_clear got %b exp 0000", bus.Pending); end
        checks++; if (bus.Busy !== 1'b1 || bus.Intr !== 1'b0) begin errors++; $display("FAIL basic_service got busy %b intr %b exp 1 0", bus.Busy, bus.Intr); end
        pulse_eret();
        checks++; if (bus.Busy !== 1'b0 || bus.Intr !== 1'b0) begin errors++; $display("FAIL basic_eret got busy %b intr %b exp 0 0", bus.Busy, bus.Intr); end
        bus.Irq = 4'b0000;
        tick(4);
    endtask

    task automatic test_priority();
        int n;
        bus.Irq = 4'b1010;
        wait_intr(n);
        checks++; if (n >= 10) begin errors++; $display("FAIL prio_timeout got %0d cycles exp <10", n); end
        checks++; if (bus.Pending !== 4'b1010) begin errors++; $display("FAIL prio_pending got %b exp 1010", bus.Pending); end
        pulse_inta();
        checks++; if (bus.Cause !== 2'd1) begin errors++; $display("FAIL prio_cause1 got %0d exp 1", bus.Cause); end
        checks++; if (bus.Pending !== 4'b1000) begin errors++; $display("FAIL prio_pending2 got %b exp 1000", bus.Pending); end
        pulse_eret();
        checks++; if (bus.Intr !== 1'b0) begin errors++; $display("FAIL b2b_eret_intr got %b exp 0", bus.Intr); end
        tick(1);
        checks++; if (bus.Intr !== 1'b1) begin errors++; $display("FAIL b2b_reassert got %b exp 1", bus.Intr); end
        pulse_inta();
        checks++; if (bus.Cause !== 2'd3) begin errors++; $display("FAIL prio_cause3 got %0d exp 3", bus.Cause); end
        checks++; if (bus.Pending !== 4'b0000) begin errors++; $display("FAIL prio_pending3 got %b exp 0000", bus.Pending); end
        pulse_eret();
        bus.Irq = 4'b0000;
        tick(4);
    endtask

    task automatic test_mask();
        bus.Mask_we = 1'b1; bus.Mask_d = 4'b1110;
        tick(1);
        bus.Mask_we = 1'b0;
        checks++; if (bus.Mask_q !== 4'b1110) begin errors++; $display("FAIL mask_write got %b exp 1110", bus.Mask_q); end
        bus.Irq = 4'b0001;
        tick(6);
        checks++; if (bus.Pending !== 4'b0001) begin errors++; $display("FAIL mask_pending got %b exp 0001", bus.Pending); end
        checks++; if (bus.Intr !== 1'b0) begin errors++; $display("FAIL mask_gated got %b exp 0", bus.Intr); end
        bus.Mask_we = 1'b1; bus.Mask_d = 4'b1111;
        tick(1);
        bus.Mask_we = 1'b0;
        checks++; if (bus.Intr !== 1'b0) begin errors++; $display("FAIL mask_next_cycle got %b exp 0", bus.Intr); end
        tick(1);
        checks++; if (bus.Intr !== 1'b1) begin errors++; $display("FAIL mask_unmask_intr got %b exp 1", bus.Intr); end
        pulse_inta();
        checks++; if (bus.Cause !== 2'd0) begin errors++; $display("FAIL mask_cause got %0d exp 0", bus.Cause); end
        pulse_eret();
        bus.Irq = 4'b0000;
        tick(4);
    endtask

    task automatic test_ie_drop();
        int n;
        bus.Irq = 4'b0010;
        wait_intr(n);
        checks++; if (n >= 10) begin errors++; $display("FAIL ie_timeout got %0d cycles exp <10", n); end
        bus.Ie = 1'b0;
        tick(1);
        checks++; if (bus.Intr !== 1'b0) begin errors++; $display("FAIL ie_withdraw got %b exp 0", bus.Intr); end
        checks++; if (bus.Pending !== 4'b0010) begin errors++; $display("FAIL ie_pending got %b exp 0010", bus.Pending); end
        tick(1);
        checks++; if (bus.Intr !== 1'b0) begin errors++; $display("FAIL ie_stay_low got %b exp 0", bus.Intr); end
        bus.Ie = 1'b1;
        tick(1);
        checks++; if (bus.Intr !== 1'b1) begin errors++; $display("FAIL ie_return got %b exp 1", bus.Intr); end
    endtask

    task automatic test_same_bit();
        bus.Irq = 4'b0000;
        tick(4);
        bus.Irq = 4'b0010;
`ifdef INTR_SYNC_EN
        tick(2);
`endif
        bus.Inta = 1'b1;
        tick(1);
        bus.Inta = 1'b0;
        checks++; if (bus.Cause !== 2'd1 || bus.Busy !== 1'b1) begin errors++; $display("FAIL same_ack got cause %0d busy %b exp 1 1", bus.Cause, bus.Busy); end
        checks++; if (bus.Pending !== 4'b0010) begin errors++; $display("FAIL same_set_wins got %b exp 0010", bus.Pending); end
    endtask

    task automatic test_service_rise();
        pulse_eret();
        tick(1);
        checks++; if (bus.Intr !== 1'b1) begin errors++; $display("FAIL svc_reassert got %b exp 1", bus.Intr); end
        pulse_inta();
        checks++; if (bus.Pending !== 4'b0000) begin errors++; $display("FAIL svc_cleared got %b exp 0000", bus.Pending); end
        bus.Irq = 4'b0000;
        tick(4);
        bus.Irq = 4'b0010;
        tick(4);
        checks++; if (bus.Pending !== 4'b0010) begin errors++; $display("FAIL svc_pending got %b exp 0010", bus.Pending); end
        checks++; if (bus.Intr !== 1'b0 || bus.Busy !== 1'b1) begin errors++; $display("FAIL svc_blocked got intr %b busy %b exp 0 1", bus.Intr, bus.Busy); end
        pulse_inta();
        checks++; if (bus.Busy !== 1'b1 || bus.Pending !== 4'b0010) begin errors++; $display("FAIL svc_inta_ignored got busy %b pend %b exp 1 0010", bus.Busy, bus.Pending); end
        pulse_eret();
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL svc_eret got %b exp 0", bus.Busy); end
        tick(1);
        checks++; if (bus.Intr !== 1'b1) begin errors++; $display("FAIL svc_intr_after got %b exp 1", bus.Intr); end
    endtask

    task automatic test_spurious();
        bus.Mask_we = 1'b1; bus.Mask_d = 4'b0000;
        tick(1);
        bus.Mask_we = 1'b0;
        checks++; if (bus.Intr !== 1'b1) begin errors++; $display("FAIL spur_hold got %b exp 1", bus.Intr); end
        pulse_inta();
        checks++; if (bus.Intr !== 1'b0 || bus.Busy !== 1'b0) begin errors++; $display("FAIL spur_idle got intr %b busy %b exp 0 0", bus.Intr, bus.Busy); end
        checks++; if (bus.Pending !== 4'b0010 || bus.Cause !== 2'd1) begin errors++; $display("FAIL spur_state got pend %b cause %0d exp 0010 1", bus.Pending, bus.Cause); end
        bus.Mask_we = 1'b1; bus.Mask_d = 4'b1111;
        tick(1);
        bus.Mask_we = 1'b0;
        tick(1);
        checks++; if (bus.Intr !== 1'b1) begin errors++; $display("FAIL spur_recover got %b exp 1", bus.Intr); end
    endtask

    task automatic test_reset_mid();
        pulse_inta();
        bus.Irq = 4'b0011;
        bus.Mask_we = 1'b1; bus.Mask_d = 4'b0101;
        tick(1);
        bus.Mask_we = 1'b0;
        tick(4);
        checks++; if (bus.Busy !== 1'b1 || bus.Pending !== 4'b0001) begin errors++; $display("FAIL mid_setup got busy %b pend %b exp 1 0001", bus.Busy, bus.Pending); end
        clrn = 1'b0;
        #1;
        checks++; if (bus.Busy !== 1'b0 || bus.Intr !== 1'b0) begin errors++; $display("FAIL mid_async got busy %b intr %b exp 0 0", bus.Busy, bus.Intr); end
        checks++; if (bus.Pending !== 4'b0000 || bus.Mask_q !== 4'b1111) begin errors++; $display("FAIL mid_regs got pend %b mask %b exp 0000 1111", bus.Pending, bus.Mask_q); end
        bus.Irq = 4'b0000;
        tick(1);
        clrn = 1'b1;
        tick(1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_ie_drop();
        test_same_bit();
        test_service_rise();
        test_spurious();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
